// File: rtl/bus_led_controller_if.sv
// Processor bus bundle for the LED peripheral: address, write strobe and the
// shared tristate data bus. Each side supplies its own data and output enable;
// the interface resolves them onto BUS_DATA and releases it to 'Z' when idle.
// Handshake: there is no valid/ready pair. A bus cycle is one CLK period.
// BUS_WE=1 with an in-window address writes BUS_DATA at the posedge. BUS_WE=0
// with an in-window address is a read, and the peripheral drives BUS_DATA
// during the following cycle only.
interface bus_led_controller_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    wire  [7:0] BUS_DATA;

    // master-side write data and its output enable
    logic [7:0] wr_data;
    logic       wr_oe;

    // slave-side readback data and its output enable
    logic [7:0] rd_data;
    logic       rd_oe;

    assign BUS_DATA = rd_oe ? rd_data : (wr_oe ? wr_data : 8'hzz);

    modport master (
        output BUS_ADDR,
        output BUS_WE,
        output wr_data,
        output wr_oe,
        input  BUS_DATA,
        input  rd_oe
    );

    modport slave (
        input  BUS_ADDR,
        input  BUS_WE,
        input  BUS_DATA,
        output rd_data,
        output rd_oe
    );
endinterface

// File: rtl/bus_led_controller.sv
// Memory-mapped LED peripheral on the 8-bit processor bus.
// Registers (offsets from BASE_ADDR, NB = NUM_LEDS/8):
//   0..NB-1      ON[k]        LED bits 8k+7..8k
//   NB..2NB-1    BLINK_EN[k]  same mapping as ON
//   2NB          BLINK_DIV    blink half-period in ticks (0 = steady)
//   2NB+1        DUTY         PWM brightness (FF = fully on)
// Optional feature macro: LED_READBACK_EN enables register readback over
// BUS_DATA. Without it, BUS_DATA is never driven by this block.
// NUM_LEDS must be a multiple of 8 in 8..64; CLKS_PER_TICK must be >= 1.
module bus_led_controller #(
    parameter logic [7:0] BASE_ADDR     = 8'hC0,
    parameter int         NUM_LEDS      = 16,
    parameter int         CLKS_PER_TICK = 50000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    bus_led_controller_if.slave  bus,
    output logic [NUM_LEDS-1:0]  LEDS
);

    localparam int         NB        = NUM_LEDS / 8;
    localparam logic [7:0] WIN       = 8'(2 * NB + 2);
    localparam logic [7:0] OFS_DIV   = 8'(2 * NB);
    localparam logic [7:0] OFS_DUTY  = 8'(2 * NB + 1);
    localparam int         PW        = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_TICK - 1);

    // Register file
    logic [NUM_LEDS-1:0] on_q, on_d;
    logic [NUM_LEDS-1:0] blink_en_q, blink_en_d;
    logic [7:0]          blink_div_q, blink_div_d;
    logic [7:0]          duty_q, duty_d;

    // Timing state
    logic [PW-1:0]       presc_q, presc_d;
    logic [7:0]          blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;
    logic [7:0]          pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;

    // Address decode: offset wraps modulo 256, so addresses below the base
    // land far outside the window.
    logic [7:0] ofs;
    logic       in_win;
    logic       wr_hit;
    logic       div_wr;
    logic       tick;
    logic       pwm_on;

    assign ofs    = bus.BUS_ADDR - BASE_ADDR;
    assign in_win = (ofs < WIN);
    assign wr_hit = bus.BUS_WE & in_win;

    // Register writes: the addressed register takes BUS_DATA at the edge.
    always_comb begin
        on_d        = on_q;
        blink_en_d  = blink_en_q;
        blink_div_d = blink_div_q;
        duty_d      = duty_q;
        div_wr      = 1'b0;
        if (wr_hit) begin
            for (int k = 0; k < NB; k++) begin
                if (ofs == 8'(k))      on_d[8*k +: 8]       = bus.BUS_DATA;
                if (ofs == 8'(NB + k)) blink_en_d[8*k +: 8] = bus.BUS_DATA;
            end
            if (ofs == OFS_DIV) begin
                blink_div_d = bus.BUS_DATA;
                div_wr      = 1'b1;
            end
            if (ofs == OFS_DUTY) duty_d = bus.BUS_DATA;
        end
    end

    // Prescaler, blink phase and PWM counter; a BLINK_DIV write restarts blinking.
    always_comb begin
        tick        = (presc_q == PRESC_MAX);
        presc_d     = tick ? '0 : presc_q + 1'b1;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        pwm_cnt_d   = pwm_cnt_q + 8'd1;
        if (blink_div_q == 8'd0) begin
            blink_cnt_d = 8'd0;
            phase_d     = 1'b1;
        end else if (tick) begin
            if (blink_cnt_q == blink_div_q - 8'd1) begin
                blink_cnt_d = 8'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
        if (div_wr) begin
            presc_d     = '0;
            blink_cnt_d = 8'd0;
            phase_d     = 1'b1;
        end
    end

    // LED drive: on bit, gated by blink phase where enabled, gated by PWM.
    always_comb begin
        pwm_on = (pwm_cnt_q < duty_q) || (duty_q == 8'hFF);
        leds_d = on_q & (~blink_en_q | {NUM_LEDS{phase_q}}) & {NUM_LEDS{pwm_on}};
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            on_q        <= '0;
            blink_en_q  <= '0;
            blink_div_q <= 8'd0;
            duty_q      <= 8'hFF;
            presc_q     <= '0;
            blink_cnt_q <= 8'd0;
            phase_q     <= 1'b1;
            pwm_cnt_q   <= 8'd0;
            leds_q      <= '0;
        end else begin
            on_q        <= on_d;
            blink_en_q  <= blink_en_d;
            blink_div_q <= blink_div_d;
            duty_q      <= duty_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pwm_cnt_q   <= pwm_cnt_d;
            leds_q      <= leds_d;
        end
    end

    assign LEDS = leds_q;

`ifdef LED_READBACK_EN
    logic       rd_hit;
    logic [7:0] rd_val;
    logic [7:0] rd_buf_q;
    logic       rd_oe_q;

    assign rd_hit = ~bus.BUS_WE & in_win;

    // Readback mux: select the addressed register byte.
    always_comb begin
        rd_val = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (ofs == 8'(k))      rd_val = on_q[8*k +: 8];
            if (ofs == 8'(NB + k)) rd_val = blink_en_q[8*k +: 8];
        end
        if (ofs == OFS_DIV)  rd_val = blink_div_q;
        if (ofs == OFS_DUTY) rd_val = duty_q;
    end

    // Read buffer: capture on an in-window read, drive for exactly one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_buf_q <= 8'h00;
            rd_oe_q  <= 1'b0;
        end else begin
            rd_oe_q <= rd_hit;
            if (rd_hit) rd_buf_q <= rd_val;
        end
    end

    assign bus.rd_data = rd_buf_q;
    assign bus.rd_oe   = rd_oe_q;
`else
    assign bus.rd_data = 8'h00;
    assign bus.rd_oe   = 1'b0;
`endif

endmodule
